// File: rtl/sad_accum_16_if.sv
// Streaming pixel-in / SAD-vector-out bundle for sad_accum_16.
// Master drives pixels and consumes results; slave is the accumulator.
interface sad_accum_16_if #(
  parameter int PIXEL_BIT_DEPTH   = 8,
  parameter int ELEMENT_BIT_DEPTH = 14
);
  logic                            in_valid;
  logic                            in_ready;
  logic [PIXEL_BIT_DEPTH-1:0]      cur_pix;
  logic [PIXEL_BIT_DEPTH*16-1:0]   ref_pix;
  logic                            sad_valid;
  logic                            sad_ready;
  logic [ELEMENT_BIT_DEPTH*16-1:0] sad_array;

  modport master (
    output in_valid, cur_pix, ref_pix, sad_ready,
    input  in_ready, sad_valid, sad_array
  );

  modport slave (
    input  in_valid, cur_pix, ref_pix, sad_ready,
    output in_ready, sad_valid, sad_array
  );
endinterface

// File: rtl/sad_accum_16.sv
// Sixteen parallel sum-of-absolute-differences accumulators over one block of
// streamed pixels; the finished vector is held until the downstream selector takes it.
module sad_accum_16 #(
  parameter int PIXEL_BIT_DEPTH   = 8,
  parameter int BLOCK_PIXELS      = 64,
  parameter int ELEMENT_BIT_DEPTH = 14
) (
  input  logic           clk,
  input  logic           rst,
  sad_accum_16_if.slave  bus
);
  localparam int P     = PIXEL_BIT_DEPTH;
  localparam int E     = ELEMENT_BIT_DEPTH;
  localparam int CNT_W = (BLOCK_PIXELS > 1) ? $clog2(BLOCK_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_PIXELS - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             sad_valid_q, sad_valid_d;
  logic             accept;
  logic             first_beat;

  assign accept     = in_ready_q && bus.in_valid;
  assign first_beat = (beat_cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = HOLD;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (sad_valid_q && bus.sad_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
    // Handshake flags are registered copies of the next state.
    in_ready_d  = (state_d == ACCUM);
    sad_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      beat_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      sad_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      in_ready_q  <= in_ready_d;
      sad_valid_q <= sad_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.sad_valid = sad_valid_q;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lane
      logic [P-1:0] ref_k;
      logic [P-1:0] diff;
      logic [E:0]   sum;
      logic [E-1:0] acc_q, acc_d;

      assign ref_k = bus.ref_pix[gi*P +: P];
      assign diff  = (bus.cur_pix >= ref_k) ? (bus.cur_pix - ref_k) : (ref_k - bus.cur_pix);
      assign sum   = {1'b0, acc_q} + (E+1)'(diff);

      // First beat of a block overwrites, so stale sums never leak into the next block.
      always_comb begin
        acc_d = acc_q;
        if (accept) begin
          if (first_beat) begin
            acc_d = E'(diff);
          end else if (sum[E]) begin
            acc_d = '1;
          end else begin
            acc_d = sum[E-1:0];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_q <= '0;
        end else begin
          acc_q <= acc_d;
        end
      end

      assign bus.sad_array[gi*E +: E] = acc_q;
    end
  endgenerate
endmodule
